shifter_pipe: RTL and testbench
===============================

// Module: shifter_pipe
// PURPOSE
//   Parametrised, fully pipelined barrel shifter: one register stage per log2 layer, valid/ready handshake.
//   Adds arithmetic right shift and back-pressure to the 16-bit combinational shifter used by the ALU.
//   Sits between the execute-stage operand mux and the writeback result mux of the multi-cycle datapath.
// PARAMETERS
//   WIDTH  16               data width; power of two, >= 2
//   CNT_W  $clog2(WIDTH)    shift-count width = number of layers = number of pipeline stages
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      in_data/in_cnt/in_op valid this cycle
//   in_ready   out  1      stage 0 can accept; transfer when in_valid && in_ready
//   in_data    in   WIDTH  operand
//   in_cnt     in   CNT_W  shift amount, 0..WIDTH-1
//   in_op      in   3      000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 SRA, others = pass-through
//   out_valid  out  1      out_data valid
//   out_ready  in   1      consumer accepts; transfer when out_valid && out_ready
//   out_data   out  WIDTH  result
//   out_zero   out  1      only with SHIFTER_ZERO_FLAG_EN: out_data == 0
// BEHAVIOUR
//   - Reset (async assert, sync deassert upstream): all stage valid = 0, all stage data/cnt/op = 0;
//     hence out_valid = 0, out_data = 0, out_zero = 1; in_ready = 1 once reset is released.
//   - Stage k (k = 0..CNT_W-1) applies a shift of 2^k when cnt[k] = 1, else passes; op and cnt travel with data.
//   - Left shifts fill 0s; SRL fills 0s; SRA fills copies of the original bit WIDTH-1; rotates wrap exactly 2^k.
//   - Undefined op: data unchanged through every stage, no error.
//   - Stall rule: ready_k = !valid_k || ready_{k+1}; ready_CNT_W = out_ready; in_ready = ready_0 (combinational chain).
//   - Stage k loads when ready_k; its valid becomes valid_{k-1} (in_valid for k = 0); data unchanged when not ready.
//   - Latency: item accepted at edge E presents out_valid after edge E+CNT_W-1 (CNT_W cycles incl. accept cycle).
//   - Throughput one item per cycle while out_ready = 1; in-order, no drop, no duplication under any stall pattern.
//   - Full pipeline with out_ready = 0: in_ready = 0; out_data/out_valid held stable until accepted.
//   - Simultaneous output pop and input push on a full pipe: both occur in the same cycle.
//   - in_cnt = 0: result == in_data for every op.
//   - Reset mid-operation: in-flight items discarded immediately; nothing emitted after release until new input.
// CONFIGURATION
//   SHIFTER_ZERO_FLAG_EN defined: out_zero port present, registered alongside out_data in final stage.
//   Undefined: out_zero port absent; no extra logic; all other behaviour identical.
// STRUCTURE
//   shifter_pkg: op encodings (OP_ROL, OP_SLL, OP_ROR, OP_SRL, OP_SRA), OP_W = 3.
//   Sub-module shifter_pipe_stage (param WIDTH, SHIFT = 2^k): one mux layer + data/cnt/op/valid regs;
//   top generates CNT_W instances and the ready chain. SRA sign bit carried per stage (original MSB).
// TESTING (WIDTH = 16, CNT_W = 4, latency 4)
//   ROR 0x1234 by 8 -> 0x3412; ROR 0x0001 by 1 -> 0x8000; ROL 0x8001 by 1 -> 0x0003.
//   SLL 0x8001 by 1 -> 0x0002; SRL 0x8000 by 15 -> 0x0001; SRA 0x8000 by 15 -> 0xFFFF; SRA 0x4000 by 14 -> 0x0001.
//   cnt 0, every op incl. undefined 111, data 0xA5C3 -> 0xA5C3; out_zero 0 (SLL 0x0001 by 0 -> 0x0001).
//   16 back-to-back items, out_ready low 3 cycles mid-stream -> in_ready low once 4 held, all 16 out in order.
//   out_ready = 1 steady -> one result per cycle, first out_valid 4 cycles after first accept.
//   rst_n low with 3 items in flight -> out_valid 0 same cycle, no output after release until new in_valid.
//   ZERO_FLAG build: SLL 0x8000 by 1 -> out_data 0x0000, out_zero 1.

Source files
------------

// File: rtl/shifter_pkg.sv
// shifter_pkg
//   Shared definitions for the pipelined barrel shifter (shifter_pipe).
//   Contents: OP_W (operation field width) and the operation encodings.
//   Encodings not listed in op_e are legal and mean "pass data through unchanged".
package shifter_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ROL = 3'b000,
    OP_SLL = 3'b001,
    OP_ROR = 3'b010,
    OP_SRL = 3'b011,
    OP_SRA = 3'b100
  } op_e;

endpackage

// File: rtl/shifter_pipe_stage.sv
// shifter_pipe_stage
//   One layer of the pipelined barrel shifter: applies a shift of SHIFT
//   positions when cnt bit log2(SHIFT) is set, else passes the operand, then
//   registers data together with the cnt/op/sign/valid fields that travel
//   alongside it.
// Parameters
//   WIDTH  data width
//   SHIFT  shift amount of this layer (a power of two, < WIDTH)
//   CNT_W  shift-count width
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   load                        stage may capture (its ready)
//   prev_valid/data/cnt/op/sign fields from the upstream stage (or the input port)
//   result                      combinational output of this layer's mux
//   valid/data/cnt/op/sign      registered fields presented downstream
module shifter_pipe_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHIFT = 1,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [CNT_W-1:0] prev_cnt,
  input  logic [OP_W-1:0]  prev_op,
  input  logic             prev_sign,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt,
  output logic [OP_W-1:0]  op,
  output logic             sign
);

  localparam int BIT = $clog2(SHIFT);

  // Arithmetic fills use the operand's original MSB (prev_sign), not the
  // current MSB, which earlier layers may already have replaced.
  always_comb begin
    result = prev_data;
    if (prev_cnt[BIT]) begin
      case (prev_op)
        OP_ROL:  result = (prev_data << SHIFT) | (prev_data >> (WIDTH - SHIFT));
        OP_SLL:  result = prev_data << SHIFT;
        OP_ROR:  result = (prev_data >> SHIFT) | (prev_data << (WIDTH - SHIFT));
        OP_SRL:  result = prev_data >> SHIFT;
        OP_SRA:  result = (prev_data >> SHIFT) |
                          (prev_sign ? ~({WIDTH{1'b1}} >> SHIFT) : '0);
        default: result = prev_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      cnt   <= '0;
      op    <= '0;
      sign  <= 1'b0;
    end else if (load) begin
      valid <= prev_valid;
      data  <= result;
      cnt   <= prev_cnt;
      op    <= prev_op;
      sign  <= prev_sign;
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// shifter_pipe
//   Fully pipelined barrel shifter, one register stage per log2 layer
//   (CNT_W stages). Supports ROL, SLL, ROR, SRL, SRA; other op codes pass
//   the operand through unchanged.
// Optional build macro
//   SHIFTER_ZERO_FLAG_EN  adds out_zero, registered with out_data in the
//                         final stage (1 when out_data == 0).
// Parameters
//   WIDTH  data width (power of two, >= 2)
//   CNT_W  shift-count width = number of pipeline stages
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_data, in_cnt, in_op operand fields
//   out_valid/out_ready  output handshake; out_data result
//   out_zero             (SHIFTER_ZERO_FLAG_EN only) out_data == 0
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer holds valid and its payload stable until the transfer; out_data and
// out_valid are held stable while out_ready is low. Stage k may load when it
// is empty or the stage after it is loading (ready_k = !valid_k ||
// ready_{k+1}, ready_CNT_W = out_ready), so a full pipe pops and pushes in the
// same cycle.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  // Index 0 is the input port; index k+1 is the register bank of stage k.
  logic             v_s  [CNT_W+1];
  logic [WIDTH-1:0] d_s  [CNT_W+1];
  logic [CNT_W-1:0] c_s  [CNT_W+1];
  logic [OP_W-1:0]  o_s  [CNT_W+1];
  logic             sg_s [CNT_W+1];
  logic [CNT_W-1:0][WIDTH-1:0] res_s;
  logic [CNT_W:0]   rdy;

  assign v_s[0]  = in_valid;
  assign d_s[0]  = in_data;
  assign c_s[0]  = in_cnt;
  assign o_s[0]  = in_op;
  assign sg_s[0] = in_data[WIDTH-1];

  // Ready ripples back from the consumer through every stage in one cycle.
  always_comb begin
    rdy        = '0;
    rdy[CNT_W] = out_ready;
    for (int k = CNT_W - 1; k >= 0; k--) begin
      rdy[k] = !v_s[k+1] || rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < CNT_W; k++) begin : g_stage
    shifter_pipe_stage #(
      .WIDTH (WIDTH),
      .SHIFT (2 ** k),
      .CNT_W (CNT_W)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (rdy[k]),
      .prev_valid (v_s[k]),
      .prev_data  (d_s[k]),
      .prev_cnt   (c_s[k]),
      .prev_op    (o_s[k]),
      .prev_sign  (sg_s[k]),
      .result     (res_s[k]),
      .valid      (v_s[k+1]),
      .data       (d_s[k+1]),
      .cnt        (c_s[k+1]),
      .op         (o_s[k+1]),
      .sign       (sg_s[k+1])
    );
  end

  assign out_valid = v_s[CNT_W];
  assign out_data  = d_s[CNT_W];

`ifdef SHIFTER_ZERO_FLAG_EN
  // Loads on the same condition as the final stage, so it always describes
  // the out_data currently presented. Reset data is 0, hence reset value 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero <= 1'b1;
    end else if (rdy[CNT_W-1]) begin
      out_zero <= (res_s[CNT_W-1] == '0);
    end
  end
`endif

  // The last stage's side fields and the per-stage mux outputs have no
  // consumer in the top level; gathered here so their disuse is deliberate.
  logic unused_tail;
  assign unused_tail = ^{c_s[CNT_W], o_s[CNT_W], sg_s[CNT_W], res_s};

endmodule

// File: tb/tb_shifter_pipe.sv
module tb_shifter_pipe;
  import shifter_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [CNT_W-1:0] in_cnt = '0;
  logic [OP_W-1:0]  in_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
`ifdef SHIFTER_ZERO_FLAG_EN
  logic             out_zero;
`endif

  always #5 clk = ~clk;

  shifter_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFTER_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_in   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_d;
  logic [WIDTH-1:0] held_d;
  logic             hold = 1'b0;

  // Reference: whole-word arithmetic on the full shift amount.
  function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] d,
                                                 input int c,
                                                 input logic [OP_W-1:0] op);
    logic [2*WIDTH-1:0] dd;
    dd = {d, d};
    case (op)
      3'd0: begin dd = dd << c; return dd[2*WIDTH-1:WIDTH]; end
      3'd1: return d << c;
      3'd2: begin dd = dd >> c; return dd[WIDTH-1:0]; end
      3'd3: return d >> c;
      3'd4: return $signed(d) >>> c;
      default: return d;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge, midway between active edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", {31'b0, out_valid}, 1);
        check("hold_data", {16'b0, out_data}, {16'b0, held_d});
      end
      hold   = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out: observed out_data %h with no item in flight", out_data);
        end
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          check("out_data", {16'b0, out_data}, {16'b0, exp_d});
`ifdef SHIFTER_ZERO_FLAG_EN
          check("out_zero", {31'b0, out_zero}, {31'b0, (exp_d == '0)});
`endif
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_data, int'(in_cnt), in_op));
        n_in++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c,
                       input logic [OP_W-1:0] op);
    int tries;
    tries    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_cnt   = c;
    in_op    = op;
    @(negedge clk);
    while (!in_ready && tries < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      tries++;
    end
    checks++;
    assert (in_ready) else begin
      errors++;
      $error("FAIL drive_accept: in_ready %0b after %0d cycles, required 1", in_ready, tries);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [WIDTH-1:0] d,
                         input logic [CNT_W-1:0] c, input logic [OP_W-1:0] op,
                         input logic [WIDTH-1:0] exp);
    int t;
    drive(d, c, op);
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "_valid"}, {31'b0, out_valid}, 1);
    check(tag, {16'b0, out_data}, {16'b0, exp});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: %0d items still pending, required 0", exp_q.size());
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int base;
    int cyc;
    int sent;
    bit saw_low;
    bit pending;
    logic [WIDTH-1:0] items[16];

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", {16'b0, out_data}, 0);
`ifdef SHIFTER_ZERO_FLAG_EN
    check("rst_out_zero", {31'b0, out_zero}, 1);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'b0, in_ready}, 1);
    out_ready = 1'b1;

    // Directed vectors with spec-given results
    run_one("ror_8",   16'h1234, 4'd8,  OP_ROR, 16'h3412);
    run_one("ror_1",   16'h0001, 4'd1,  OP_ROR, 16'h8000);
    run_one("rol_1",   16'h8001, 4'd1,  OP_ROL, 16'h0003);
    run_one("sll_1",   16'h8001, 4'd1,  OP_SLL, 16'h0002);
    run_one("srl_15",  16'h8000, 4'd15, OP_SRL, 16'h0001);
    run_one("sra_15",  16'h8000, 4'd15, OP_SRA, 16'hFFFF);
    run_one("sra_14",  16'h4000, 4'd14, OP_SRA, 16'h0001);
    run_one("sll_0",   16'h0001, 4'd0,  OP_SLL, 16'h0001);
    run_one("sll_zero",16'h8000, 4'd1,  OP_SLL, 16'h0000);
    for (int op = 0; op < 8; op++) begin
      run_one("cnt0", 16'hA5C3, 4'd0, op[2:0], 16'hA5C3);
    end
    run_one("undef_op", 16'hA5C3, 4'd7, 3'b111, 16'hA5C3);

    // Latency: first out_valid after the 4th edge counting the accept edge
    drive(16'h00F0, 4'd4, OP_ROL);
    check("lat_e0", {31'b0, out_valid}, 0);
    @(posedge clk); #1;
    check("lat_e1", {31'b0, out_valid}, 0);
    @(posedge clk); #1;
    check("lat_e2", {31'b0, out_valid}, 0);
    @(posedge clk); #1;
    check("lat_e3", {31'b0, out_valid}, 1);
    drain();

    // Throughput: 8 back-to-back items, one result per cycle
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      drive(WIDTH'($urandom), CNT_W'($urandom_range(0, 15)), OP_W'($urandom_range(0, 4)));
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("tput_count", n_out - base, 7);
    check("tput_valid", {31'b0, out_valid}, 1);
    drain();

    // 16 back-to-back items with out_ready low for 3 cycles mid-stream
    for (int i = 0; i < 16; i++) items[i] = WIDTH'($urandom);
    base    = n_out;
    sent    = 0;
    cyc     = 0;
    saw_low = 1'b0;
    while (sent < 16 && cyc < 200) begin
      out_ready = !(cyc >= 6 && cyc < 9);
      in_valid  = 1'b1;
      in_data   = items[sent];
      in_cnt    = CNT_W'(sent);
      in_op     = OP_W'(sent % 5);
      @(negedge clk);
      if (!in_ready) saw_low = 1'b1;
      if (in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stall_in_ready_low", {31'b0, saw_low}, 1);
    drain();
    check("stall_count", n_out - base, 16);

    // Random traffic with random back-pressure
    base    = n_out;
    cyc     = n_in;
    pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = WIDTH'($urandom);
        in_cnt   = CNT_W'($urandom_range(0, 15));
        in_op    = OP_W'($urandom_range(0, 7));
        pending  = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) pending = 1'b0;
      @(posedge clk); #1;
      if (!pending) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("rand_count", n_out - base, n_in - cyc);

    // Reset with 3 items in flight
    out_ready = 1'b0;
    drive(16'h1111, 4'd1, OP_SLL);
    drive(16'h2222, 4'd2, OP_SRL);
    drive(16'h3333, 4'd3, OP_ROR);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 0);
    check("mid_rst_out_data", {16'b0, out_data}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    base      = n_out;
    repeat (10) begin
      @(posedge clk); #1;
      check("post_rst_idle", {31'b0, out_valid}, 0);
    end
    check("post_rst_count", n_out - base, 0);
    run_one("post_rst_rol", 16'h0001, 4'd1, OP_ROL, 16'h0002);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
